// File: rtl/sparrow_pkg.sv
// Shared types and helpers for the sparrow data-memory path.
// Holds the LSU access-size encoding, the dmem responder state type and the
// lane-mask / store-replicate / load-extend helpers used by sparrow_dmem.
package sparrow_pkg;

  // LSU access size; encoding 2'b10 is reserved and rejected by the responder
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  function automatic logic [3:0] lane_mask(mem_access_size_e size, logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      BYTE:      mask = 4'b0001 << offset;
      HALF_WORD: mask = 4'b0011 << {offset[1], 1'b0};
      WORD:      mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // LSB-justified store data copied onto every lane the mask may select
  function automatic logic [31:0] store_replicate(mem_access_size_e size, logic [31:0] data);
    logic [31:0] rep;
    case (size)
      BYTE:      rep = {4{data[7:0]}};
      HALF_WORD: rep = {2{data[15:0]}};
      default:   rep = data;
    endcase
    return rep;
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] word, mem_access_size_e size,
                                              logic [1:0] offset, logic zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (size)
      BYTE:      res = zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
      HALF_WORD: res = zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sparrow_dmem_ram.sv
// Single-port synchronous data RAM, DEPTH_WORDS x 32, per-byte write enable,
// registered read port. Contents are not reset.
module sparrow_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write or registered read of the addressed word
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sparrow_dmem.sv
// Data-memory responder for the core's dmem request interface.
// One outstanding request; WAIT_STATES extra cycles between grant and the
// one-cycle rvalid pulse. Range, size (and optionally alignment) errors give
// err=1 with rd_data=0 and no RAM write.
// Optional: define SPARROW_DMEM_MISALIGN_ERR_EN to reject misaligned half/word
// accesses; otherwise misaligned low address bits are ignored.
module sparrow_dmem
  import sparrow_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req_i,
  output logic        dmem_gnt_o,
  input  logic [31:0] dmem_addr_i,
  input  logic        dmem_wr_en_i,
  input  logic [1:0]  dmem_byte_en_i,
  input  logic        dmem_zero_extend_i,
  input  logic [31:0] dmem_wr_data_i,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_e state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        zx_q;
  logic [31:0] wdata_q;
  logic        rvalid_q;
  logic        rsp_err_q;
  logic        rsp_load_q;

  logic        gnt;
  logic        commit;
  logic [31:0] c_addr;
  logic        c_wr;
  logic [1:0]  c_size;
  logic [31:0] c_wdata;
  logic [31:0] c_off;
  logic        c_in_range;
  logic        c_size_ok;
  logic        c_misalign;
  logic        c_err;
  logic [31:0] ram_rdata;

  assign gnt        = dmem_req_i && ((state_q == IDLE) || (state_q == RESP));
  assign dmem_gnt_o = gnt;

  // With no wait states the commit edge is the grant edge, so the RAM must be
  // driven from the live request; otherwise from the latched copy.
  always_comb begin
    if (WAIT_STATES == 0) begin
      commit  = gnt;
      c_addr  = dmem_addr_i;
      c_wr    = dmem_wr_en_i;
      c_size  = dmem_byte_en_i;
      c_wdata = dmem_wr_data_i;
    end else begin
      commit  = (state_q == WAIT) && (cnt_q == '0);
      c_addr  = addr_q;
      c_wr    = wr_q;
      c_size  = size_q;
      c_wdata = wdata_q;
    end
  end

  // BASE_ADDR is DEPTH_WORDS*4 aligned, so the low offset bits equal the address bits
  assign c_off      = c_addr - BASE_ADDR;
  assign c_in_range = (c_off[31:AW+2] == '0);
  assign c_size_ok  = (c_size != 2'b10);
`ifdef SPARROW_DMEM_MISALIGN_ERR_EN
  assign c_misalign = ((mem_access_size_e'(c_size) == HALF_WORD) && c_off[0]) ||
                      ((mem_access_size_e'(c_size) == WORD) && (c_off[1:0] != 2'b00));
`else
  assign c_misalign = 1'b0;
`endif
  assign c_err = !c_in_range || !c_size_ok || c_misalign;

  sparrow_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (commit && !c_err),
    .we_i    (c_wr),
    .be_i    (lane_mask(mem_access_size_e'(c_size), c_off[1:0])),
    .addr_i  (c_off[AW+1:2]),
    .wdata_i (store_replicate(mem_access_size_e'(c_size), c_wdata)),
    .rdata_o (ram_rdata)
  );

  // Request FSM: latch on grant, count wait states, registered response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      size_q     <= '0;
      zx_q       <= 1'b0;
      wdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      rvalid_q   <= commit;
      rsp_err_q  <= commit && c_err;
      rsp_load_q <= commit && !c_wr && !c_err;
      case (state_q)
        IDLE, RESP: begin
          if (gnt) begin
            addr_q  <= dmem_addr_i;
            wr_q    <= dmem_wr_en_i;
            size_q  <= dmem_byte_en_i;
            zx_q    <= dmem_zero_extend_i;
            wdata_q <= dmem_wr_data_i;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load data extracted from the registered RAM word; zero for stores/errors
  always_comb begin
    dmem_rd_data_o = '0;
    if (rsp_load_q) begin
      dmem_rd_data_o = load_extend(ram_rdata, mem_access_size_e'(size_q), addr_q[1:0], zx_q);
    end
  end

  assign dmem_rvalid_o = rvalid_q;
  assign dmem_err_o    = rsp_err_q;

endmodule

// File: tb/tb_sparrow_dmem.sv
// Directed bench for sparrow_dmem: a WAIT_STATES=1 instance driven from a
// vector table plus reset-in-WAIT, and a WAIT_STATES=0 instance driven
// back-to-back.
module tb_sparrow_dmem;
  import sparrow_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_STATES = 1 instance
  logic        req_a, gnt_a, wr_a, zx_a, rv_a, err_a;
  logic [1:0]  be_a;
  logic [31:0] addr_a, wd_a, rd_a;
  // WAIT_STATES = 0 instance
  logic        req_b, gnt_b, wr_b, zx_b, rv_b, err_b;
  logic [1:0]  be_b;
  logic [31:0] addr_b, wd_b, rd_b;

  sparrow_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_2000)) dut_a (
    .clk(clk), .rst(rst), .dmem_req_i(req_a), .dmem_gnt_o(gnt_a), .dmem_addr_i(addr_a),
    .dmem_wr_en_i(wr_a), .dmem_byte_en_i(be_a), .dmem_zero_extend_i(zx_a),
    .dmem_wr_data_i(wd_a), .dmem_rvalid_o(rv_a), .dmem_rd_data_o(rd_a), .dmem_err_o(err_a));

  sparrow_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_2000)) dut_b (
    .clk(clk), .rst(rst), .dmem_req_i(req_b), .dmem_gnt_o(gnt_b), .dmem_addr_i(addr_b),
    .dmem_wr_en_i(wr_b), .dmem_byte_en_i(be_b), .dmem_zero_extend_i(zx_b),
    .dmem_wr_data_i(wd_b), .dmem_rvalid_o(rv_b), .dmem_rd_data_o(rd_b), .dmem_err_o(err_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        zx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic w, logic [1:0] s, logic z, logic [31:0] a,
                              logic [31:0] d, logic [31:0] er, logic ee);
    vec_t v;
    v.name = n; v.wr = w; v.size = s; v.zx = z; v.addr = a;
    v.wdata = d; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  // One access on dut_a; lat counts negedges from the grant cycle to rvalid
  task automatic access(input logic wr, input logic [1:0] sz, input logic zx,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_a = 1'b1; wr_a = wr; be_a = sz; zx_a = zx; addr_a = a; wd_a = d;
    #1 chk("gnt_idle", {31'b0, gnt_a}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    lat = 1;
    while (!rv_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rd_a;
    er = err_a;
    @(negedge clk);
    chk("rvalid_pulse", {31'b0, rv_a}, 32'd0);
  endtask

  // Back-to-back word accesses on dut_b with req held high
  task automatic b2b(input logic wr, input string tag);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk({tag, "_rvalid"}, {31'b0, rv_b}, 32'd1);
        chk({tag, "_data"}, rd_b, wr ? 32'h0 : (32'hA000_0000 + 32'(i - 1)));
        chk({tag, "_err"}, {31'b0, err_b}, 32'd0);
      end
      if (i < 4) begin
        req_b = 1'b1; wr_b = wr; be_b = WORD; zx_b = 1'b0;
        addr_b = 32'h2040 + 32'(4 * i); wd_b = 32'hA000_0000 + 32'(i);
        #1 chk({tag, "_gnt"}, {31'b0, gnt_b}, 32'd1);
      end else begin
        req_b = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_idle"}, {31'b0, rv_b}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1;
    req_a = 0; wr_a = 0; be_a = 0; zx_a = 0; addr_a = 0; wd_a = 0;
    req_b = 0; wr_b = 0; be_b = 0; zx_b = 0; addr_b = 0; wd_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {31'b0, gnt_a}, 32'd0);
    chk("rst_rvalid", {31'b0, rv_a}, 32'd0);
    chk("rst_rdata", rd_a, 32'h0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rvalid", {31'b0, rv_a}, 32'd0);

    vecs.push_back(mk("sw_2004",   1, WORD,      0, 32'h2004, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk("lw_2004",   0, WORD,      0, 32'h2004, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk("sw_2008",   1, WORD,      0, 32'h2008, 32'h11223344, 32'h0,        0));
    vecs.push_back(mk("sb_2009",   1, BYTE,      0, 32'h2009, 32'h00000080, 32'h0,        0));
    vecs.push_back(mk("lb_2009",   0, BYTE,      0, 32'h2009, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu_2009",  0, BYTE,      1, 32'h2009, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk("lw_2008",   0, WORD,      0, 32'h2008, 32'h0,        32'h11228044, 0));
    vecs.push_back(mk("sw_200c",   1, WORD,      0, 32'h200C, 32'h0,        32'h0,        0));
    vecs.push_back(mk("sh_200e",   1, HALF_WORD, 0, 32'h200E, 32'h00008001, 32'h0,        0));
    vecs.push_back(mk("lh_200e",   0, HALF_WORD, 0, 32'h200E, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("lhu_200e",  0, HALF_WORD, 1, 32'h200E, 32'h0,        32'h00008001, 0));
    vecs.push_back(mk("lw_200c",   0, WORD,      0, 32'h200C, 32'h0,        32'h80010000, 0));
    vecs.push_back(mk("sw_2000",   1, WORD,      0, 32'h2000, 32'h12345678, 32'h0,        0));
    vecs.push_back(mk("lw_1ffc",   0, WORD,      0, 32'h1FFC, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lw_3000",   0, WORD,      0, 32'h3000, 32'h0,        32'h0,        1));
    vecs.push_back(mk("sw_3000",   1, WORD,      0, 32'h3000, 32'hAAAAAAAA, 32'h0,        1));
    vecs.push_back(mk("sw_badsz",  1, 2'b10,     0, 32'h2000, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lw_badsz",  0, 2'b10,     0, 32'h2004, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lw_2000",   0, WORD,      0, 32'h2000, 32'h0,        32'h12345678, 0));
    vecs.push_back(mk("lw_2004b",  0, WORD,      0, 32'h2004, 32'h0,        32'hDEADBEEF, 0));
`ifdef SPARROW_DMEM_MISALIGN_ERR_EN
    vecs.push_back(mk("lw_2002",   0, WORD,      0, 32'h2002, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lh_2001",   0, HALF_WORD, 0, 32'h2001, 32'h0,        32'h0,        1));
`else
    vecs.push_back(mk("lw_2002",   0, WORD,      0, 32'h2002, 32'h0,        32'h12345678, 0));
    vecs.push_back(mk("lh_2001",   0, HALF_WORD, 1, 32'h2001, 32'h0,        32'h00005678, 0));
`endif
    vecs.push_back(mk("sb_2003",   1, BYTE,      0, 32'h2003, 32'h0000005A, 32'h0,        0));
    vecs.push_back(mk("lbu_2003",  0, BYTE,      1, 32'h2003, 32'h0,        32'h0000005A, 0));
    vecs.push_back(mk("lw_2000b",  0, WORD,      0, 32'h2000, 32'h0,        32'h5A345678, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].wr, vecs[i].size, vecs[i].zx, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
    end

    // Reset asserted while a store sits in WAIT: nothing committed, no response
    access(1'b1, WORD, 1'b0, 32'h2010, 32'h01020304, rd, er, lat);
    chk("pre_sw_err", {31'b0, er}, 32'd0);
    @(negedge clk);
    req_a = 1'b1; wr_a = 1'b1; be_a = WORD; zx_a = 1'b0; addr_a = 32'h2010; wd_a = 32'hFFFFFFFF;
    #1 chk("rstw_gnt", {31'b0, gnt_a}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    rst = 1'b1;
    #1 chk("rstw_rvalid_in_rst", {31'b0, rv_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_no_rvalid", {31'b0, rv_a}, 32'd0);
    end
    access(1'b0, WORD, 1'b0, 32'h2010, 32'h0, rd, er, lat);
    chk("rstw_lw_lat", 32'(lat), 32'd2);
    chk("rstw_lw_data", rd, 32'h01020304);
    chk("rstw_lw_err", {31'b0, er}, 32'd0);

    // Zero wait states: stores then loads with req held high
    b2b(1'b1, "b2b_sw");
    b2b(1'b0, "b2b_lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
